ahb_lite_sram_slave: RTL and testbench
======================================

# ahb_lite_sram_slave

Parametrised AHB-Lite SRAM slave for the AHB_TOP subsystem, replacing the fixed-width single-slave memory. Supports configurable data width and depth, byte/halfword/word/doubleword writes via HSIZE byte lanes, optional programmable wait states, a write-to-read bypass, and a two-cycle ERROR response for illegal transfers. It attaches directly to the bus signals carried by the `inf` interface.

## Interface
- DATA_W, 32: data bus width; 32 or 64.
- ADDR_W, 32: HADDR width.
- DEPTH, 1024: memory depth in DATA_W-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH*DATA_W/8.
- WAIT_STATES, 2: HREADY-low cycles per OKAY data phase; 0–15. Used only with AHB_WAIT_EN.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address, address phase.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HBURST  in  3  burst type; informational only.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HPROT  in  4  protection; ignored.
- HMASTLOCK  in  1  lock; ignored.
- HWDATA  in  DATA_W  write data, data phase.
- HREADY  out  1  transfer done / bus ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_W  read data, valid when HREADY=1 in a read data phase.

## Operation
- Address phase is sampled on an HCLK edge with HREADY=1, HSEL=1 and HTRANS[1]=1 (NONSEQ/SEQ). IDLE, BUSY or HSEL=0 yields a zero-wait OKAY data phase with no memory access.
- Address, HWRITE, HSIZE and the byte offset are registered for the data phase.
- The transfer is illegal if any of these holds:
  - the address lies outside [BASE_ADDR, BASE_ADDR + DEPTH*DATA_W/8);
  - 2^HSIZE > DATA_W/8;
  - the address is not aligned to 2^HSIZE.
- Byte strobes: 2^HSIZE consecutive lanes starting at HADDR[log2(DATA_W/8)-1:0], little-endian.
- Write: HWDATA lanes are committed to memory on the edge that ends the data phase (HREADY=1). Unselected lanes are unchanged. Illegal writes never modify memory.
- Read: HRDATA holds the full addressed word, not lane-masked. If the previous data phase was a write to the same word, the written lanes are forwarded (bypass) and the other lanes come from memory.
- FSM states:
  - IDLE: HREADY=1, HRESP=0.
  - ACCESS: final data-phase cycle, HREADY=1.
  - WAIT: HREADY=0, wait counter running.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
- FSM transitions:
  - IDLE or ACCESS or ERR2 → ERR1 on an illegal valid transfer.
  - IDLE or ACCESS or ERR2 → WAIT on a legal valid transfer with WAIT_STATES>0 (AHB_WAIT_EN only).
  - IDLE or ACCESS or ERR2 → ACCESS on a legal valid transfer otherwise.
  - IDLE or ACCESS or ERR2 → IDLE when there is no valid transfer.
  - WAIT → ACCESS after WAIT_STATES cycles.
  - ERR1 → ERR2 always.
- In ERR2 a new address phase is accepted; the master may also drive IDLE to cancel the burst.
- Bursts are handled beat by beat. HBURST has no effect. BUSY inside a burst gives OKAY with no access.

## Timing
- Reset values: HREADY=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, bypass invalid. Memory contents are not reset.
- HRESET asserted mid-transfer, in any state (WAIT, ERR1, ...): the pending transfer is dropped and no memory write occurs. Outputs take their reset values on the next edge.
- Zero-wait latency: address phase at edge N, data phase completes at edge N+1.
- With wait states: HREADY is low for exactly WAIT_STATES cycles, so completion is at edge N+1+WAIT_STATES.
- Illegal transfers never take wait states. ERROR takes exactly 2 data-phase cycles (ERR1, ERR2).
- Wait counter: 4 bits, loaded with WAIT_STATES-1, decrements to 0; no wrap.
- Back-to-back write then read of the same word returns the new data with zero added latency.
- HRDATA holds its last value during HREADY=0 cycles and during write or idle data phases.

## Configuration
- AHB_WAIT_EN defined: WAIT_STATES is honoured and the WAIT state and counter are built.
- AHB_WAIT_EN undefined: WAIT and the counter are removed and all OKAY transfers are zero-wait, whatever WAIT_STATES is set to. ERROR timing is identical in both builds.

## Test plan
- Reset: HRESET=1 for 2 cycles → HREADY=1, HRESP=0, HRDATA=0.
- Word write/read, DATA_W=32: write 0xDEADBEEF to 0x10, read 0x10 → HRDATA=0xDEADBEEF, HRESP=0 both beats.
- Byte-lane and bypass: write word 0x11223344 to 0x20, then byte 0xAA to 0x21 (HSIZE=0, HWDATA=0x0000AA00), then an immediate read of 0x20 → 0x1122AA44.
- Errors: read of BASE_ADDR + DEPTH*4 → HREADY=0/HRESP=1, then HREADY=1/HRESP=1. A halfword write to 0x03 (misaligned) gives the same response, and a later read of 0x00 shows memory unchanged.
- Wait states (AHB_WAIT_EN, WAIT_STATES=3): an INCR4 read burst takes 3 HREADY-low cycles per beat. A BUSY inserted between beats 2 and 3 gives a zero-wait OKAY with no access.
- Reset mid-WAIT: assert HRESET during the second wait cycle of a write to 0x40 → the write is dropped, and a read of 0x40 after reset returns the prior value.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with byte-lane writes, write-to-read forwarding and a two-cycle ERROR response.
// Define AHB_WAIT_EN to build the programmable wait-state counter (WAIT_STATES per OKAY data phase).
module ahb_lite_sram_slave #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [1:0]        HTRANS,
    input  logic [3:0]        HPROT,
    input  logic              HMASTLOCK,
    input  logic [DATA_W-1:0] HWDATA,
    output logic              HREADY,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);
    localparam int          NB    = DATA_W / 8;
    localparam int          OFF_W = $clog2(NB);
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [63:0] LO    = 64'(BASE_ADDR);
    localparam logic [63:0] HI    = LO + 64'(DEPTH) * 64'(NB);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCESS, S_ERR1, S_ERR2
`ifdef AHB_WAIT_EN
        , S_WAIT
`endif
    } state_t;

    state_t              r_state;
    logic                r_hready, r_hresp;
    logic [DATA_W-1:0]   r_hrdata;
    logic                r_write;
    logic [IDX_W-1:0]    r_idx;
    logic [NB-1:0]       r_strb;
    logic [DATA_W-1:0]   r_mem [DEPTH];
`ifdef AHB_WAIT_EN
    logic [3:0]          r_wcnt;
`endif

    logic                w_valid, w_legal, w_commit, w_fwd;
    logic [2:0]          w_amask;
    logic [ADDR_W-1:0]   w_rel;
    logic [IDX_W-1:0]    w_idx, w_rd_idx;
    logic [OFF_W-1:0]    w_off;
    logic [NB-1:0]       w_strb;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_unused;

    assign w_valid = HSEL && HTRANS[1] && r_hready;
    assign w_amask = ~(3'b111 << HSIZE);
    assign w_legal = (64'(HADDR) >= LO) && (64'(HADDR) < HI)
                     && (HSIZE <= 3'(OFF_W)) && ((HADDR[2:0] & w_amask) == 3'b000);
    assign w_rel   = HADDR - ADDR_W'(BASE_ADDR);
    assign w_idx   = w_rel[OFF_W +: IDX_W];
    assign w_off   = HADDR[OFF_W-1:0];

    always_comb begin
        w_strb = '0;
        for (int b = 0; b < NB; b++)
            w_strb[b] = (b >= int'(w_off)) && (b < int'(w_off) + (1 << HSIZE));
    end

    // The write data phase ending on this edge may target the word being read now.
    assign w_commit = (r_state == S_ACCESS) && r_write;
`ifdef AHB_WAIT_EN
    assign w_rd_idx = (r_state == S_WAIT) ? r_idx : w_idx;
`else
    assign w_rd_idx = w_idx;
`endif
    assign w_fwd = w_commit && (r_idx == w_rd_idx);

    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        for (int b = 0; b < NB; b++)
            if (w_fwd && r_strb[b]) w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
    end

    always_ff @(posedge HCLK) begin
        if (w_commit && !HRESET)
            for (int b = 0; b < NB; b++)
                if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_hrdata <= '0;
            r_write  <= 1'b0;
            r_idx    <= '0;
            r_strb   <= '0;
`ifdef AHB_WAIT_EN
            r_wcnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
`ifdef AHB_WAIT_EN
                S_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state  <= S_ACCESS;
                        r_hready <= 1'b1;
                        if (!r_write) r_hrdata <= w_rd_word;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
`endif
                default: begin
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                    if (w_valid) begin
                        r_write <= HWRITE && w_legal;
                        r_idx   <= w_idx;
                        r_strb  <= w_strb;
                        if (!w_legal) begin
                            r_state  <= S_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end
`ifdef AHB_WAIT_EN
                        else if (WAIT_STATES > 0) begin
                            r_state  <= S_WAIT;
                            r_hready <= 1'b0;
                            r_wcnt   <= 4'(WAIT_STATES - 1);
                        end
`endif
                        else begin
                            r_state <= S_ACCESS;
                            if (!HWRITE) r_hrdata <= w_rd_word;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign HREADY = r_hready;
    assign HRESP  = r_hresp;
    assign HRDATA = r_hrdata;

    assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], w_rel, (WAIT_STATES != 0)};
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomized bench for ahb_lite_sram_slave: a byte-array memory model predicts every data-phase cycle.
module tb_ahb_lite_sram_slave;
    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          WS     = 3;
`ifdef AHB_WAIT_EN
    localparam int NW = WS;
`else
    localparam int NW = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE, HMASTLOCK;
    logic [31:0] HADDR, HWDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;
    logic [3:0]  HPROT;
    wire         HREADY, HRESP;
    wire  [31:0] HRDATA;

    ahb_lite_sram_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                          .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
        .HRDATA(HRDATA));

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [2:0]  burst;
    } txn_t;

    int          n_cmp = 0, n_bad = 0;
    bit          exp_chk = 0, exp_ready, exp_resp, exp_rd_chk;
    logic [31:0] exp_rdata;
    logic [7:0]  m_mem [DEPTH*4];
    logic [31:0] m_last_rd = '0;
    logic [31:0] cap_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (exp_chk) begin
            chk("hready", {31'b0, HREADY}, {31'b0, exp_ready});
            chk("hresp",  {31'b0, HRESP},  {31'b0, exp_resp});
            if (exp_rd_chk) chk("hrdata", HRDATA, exp_rdata);
        end
    end

    // Reference model: plain byte-addressed memory and the transfer legality rules
    function automatic bit m_legal(bit [31:0] a, bit [2:0] sz);
        return (a >= BASE) && ((a - BASE) < DEPTH * 4) && ((32'd1 << sz) <= DATA_W / 8)
               && ((a % (32'd1 << sz)) == 0);
    endfunction

    function automatic logic [31:0] m_read(bit [31:0] a);
        int w = int'((a - BASE) & ~32'd3);
        return {m_mem[w+3], m_mem[w+2], m_mem[w+1], m_mem[w]};
    endfunction

    function automatic void m_write(bit [31:0] a, bit [2:0] sz, bit [31:0] wd);
        for (int i = 0; i < (1 << sz); i++)
            m_mem[int'(a - BASE) + i] = wd[8*(int'(a[1:0]) + i) +: 8];
    endfunction

    function automatic txn_t mk(bit sel, bit [1:0] tr, bit wr, bit [2:0] sz,
                                bit [31:0] a, bit [31:0] wd, bit [2:0] bu);
        txn_t t;
        t.sel = sel; t.trans = tr; t.wr = wr; t.size = sz;
        t.addr = a; t.wdata = wd; t.burst = bu;
        return t;
    endfunction

    task automatic set_exp(input bit r, input bit e, input bit rc, input logic [31:0] d);
        exp_ready = r; exp_resp = e; exp_rd_chk = rc; exp_rdata = d; exp_chk = 1'b1;
    endtask

    task automatic step();
        @(posedge HCLK); #1;
    endtask

    task automatic drive(input txn_t t);
        HSEL = t.sel; HTRANS = t.trans; HWRITE = t.wr; HSIZE = t.size;
        HADDR = t.addr; HBURST = t.burst;
    endtask

    task automatic drive_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = '0; HBURST = 3'd0;
    endtask

    // Pipelined master: the next address phase overlaps each data phase's final cycle.
    task automatic run(input txn_t q[$]);
        drive(q[0]);
        foreach (q[k]) begin
            step();
            HWDATA = q[k].wdata;
            if (k + 1 < q.size()) drive(q[k+1]); else drive_idle();
            if (!(q[k].sel && q[k].trans[1])) begin
                set_exp(1, 0, 1, m_last_rd);
            end else if (!m_legal(q[k].addr, q[k].size)) begin
                set_exp(0, 1, 1, m_last_rd);
                step();
                set_exp(1, 1, 0, m_last_rd);
            end else begin
                repeat (NW) begin
                    set_exp(0, 0, 1, m_last_rd);
                    step();
                end
                if (q[k].wr) begin
                    set_exp(1, 0, 1, m_last_rd);
                    m_write(q[k].addr, q[k].size, q[k].wdata);
                end else begin
                    m_last_rd = m_read(q[k].addr);
                    set_exp(1, 0, 1, m_last_rd);
                    @(negedge HCLK);
                    cap_rd = HRDATA;
                end
            end
        end
        step();
        set_exp(1, 0, 1, m_last_rd);
    endtask

    initial begin
        txn_t q[$];
        HRESET = 1'b1; HWDATA = '0; HPROT = 4'd0; HMASTLOCK = 1'b0;
        drive_idle();
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        set_exp(1, 0, 1, 32'h0);
        step(); step();

        for (int i = 0; i < 64; i++) q.push_back(mk(1, 2'b10, 1, 3'd2, 32'(i * 4), $urandom, 3'd0));
        run(q);

        q.delete();
        q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF, 3'd0));
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 3'd0));
        run(q);
        chk("word_wr_rd", cap_rd, 32'hDEADBEEF);

        q.delete();
        q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h20, 32'h11223344, 3'd0));
        q.push_back(mk(1, 2'b10, 1, 3'd0, 32'h21, 32'h0000AA00, 3'd0));
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h20, 32'h0, 3'd0));
        run(q);
        chk("byte_bypass", cap_rd, 32'h1122AA44);

        q.delete();
        q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h00, 32'hCAFEF00D, 3'd0));
        q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + DEPTH * 4, 32'h0, 3'd0));
        q.push_back(mk(1, 2'b10, 1, 3'd1, 32'h03, 32'h12345678, 3'd0));
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h00, 32'h0, 3'd0));
        run(q);
        chk("err_no_write", cap_rd, 32'hCAFEF00D);

        q.delete();
        q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h8C, 32'h0BADC0DE, 3'd0));
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h80, 32'h0, 3'd3));
        q.push_back(mk(1, 2'b11, 0, 3'd2, 32'h84, 32'h0, 3'd3));
        q.push_back(mk(1, 2'b01, 0, 3'd2, 32'h88, 32'h0, 3'd3));
        q.push_back(mk(1, 2'b11, 0, 3'd2, 32'h88, 32'h0, 3'd3));
        q.push_back(mk(1, 2'b11, 0, 3'd2, 32'h8C, 32'h0, 3'd3));
        run(q);
        chk("burst_last", cap_rd, 32'h0BADC0DE);

        for (int blk = 0; blk < 40; blk++) begin
            int n = $urandom_range(1, 8);
            q.delete();
            for (int j = 0; j < n; j++) begin
                bit [2:0]  sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7))
                                                            : 3'($urandom_range(0, 2));
                bit [31:0] a;
                bit        wr = 1'($urandom_range(0, 1));
                int        r  = $urandom_range(0, 19);
                if (r == 0)      a = BASE + DEPTH * 4 + 32'($urandom_range(0, 255) * 4);
                else if (r == 1) a = 32'($urandom_range(0, 255));
                else if (r == 2) begin a = BASE + DEPTH * 4 - 4; wr = 1'b1; sz = 3'd2; end
                else             a = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 1);
                q.push_back(mk(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), wr, sz,
                               a, $urandom, 3'd1));
            end
            run(q);
        end

`ifdef AHB_WAIT_EN
        q.delete();
        q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h40, 32'h55AA55AA, 3'd0));
        run(q);
        drive(mk(1, 2'b10, 1, 3'd2, 32'h40, 32'h0, 3'd0));
        step();
        HWDATA = 32'h01234567;
        drive_idle();
        set_exp(0, 0, 1, m_last_rd);
        step();
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        m_last_rd = '0;
        set_exp(1, 0, 1, 32'h0);
        step();
        q.delete();
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h40, 32'h0, 3'd0));
        run(q);
        chk("rst_drops_write", cap_rd, 32'h55AA55AA);
`endif

        step();
        exp_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
